// File: rtl/fp_addsub_collect.sv
// Output collection stage for the FP32 add/sub unit: classifies each result,
// buffers it in a small in-order FIFO and accumulates sticky exception flags.
module fp_addsub_collect #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic                     in_overflow,
    input  logic                     in_underflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [2:0]               out_class,
    output logic                     out_overflow,
    output logic                     out_underflow,
    output logic                     sticky_overflow,
    output logic                     sticky_underflow,
    output logic                     sticky_invalid,
    input  logic                     clr_sticky,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_DENORM = 3'd1;
    localparam logic [2:0] CLS_NORMAL = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_QNAN   = 3'd4;
    localparam logic [2:0] CLS_SNAN   = 3'd5;

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  cls;
        logic        ovf;
        logic        unf;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_sticky_ovf;
    logic               r_sticky_unf;
    logic               r_sticky_inv;

    logic [7:0]         w_exp;
    logic [22:0]        w_frac;
    logic [2:0]         w_class;
    logic               w_is_nan;
    logic               w_push;
    logic               w_pop;
    entry_t             w_head;

    // IEEE-754 class of the incoming result; sign bit does not participate
    assign w_exp  = in_result[30:23];
    assign w_frac = in_result[22:0];

    always_comb begin
        w_class = CLS_NORMAL;
        if (w_exp == 8'h00) begin
            w_class = (w_frac == 23'd0) ? CLS_ZERO : CLS_DENORM;
        end else if (w_exp == 8'hFF) begin
            if (w_frac == 23'd0) begin
                w_class = CLS_INF;
            end else if (w_frac[22]) begin
                w_class = CLS_QNAN;
            end else begin
                w_class = CLS_SNAN;
            end
        end
    end

    assign w_is_nan = (w_class == CLS_QNAN) || (w_class == CLS_SNAN);

    // Handshake decode depends only on the registered occupancy
    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != CNT_W'(0));
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= '{result: in_result, cls: w_class,
                                 ovf: in_overflow, unf: in_underflow};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A set from an accepted push overrides a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_unf <= 1'b0;
            r_sticky_inv <= 1'b0;
        end else begin
            r_sticky_ovf <= (r_sticky_ovf && !clr_sticky) || (w_push && in_overflow);
            r_sticky_unf <= (r_sticky_unf && !clr_sticky) || (w_push && in_underflow);
            r_sticky_inv <= (r_sticky_inv && !clr_sticky) || (w_push && w_is_nan);
        end
    end

    assign w_head           = r_mem[r_rd_ptr];
    assign out_result       = w_head.result;
    assign out_class        = w_head.cls;
    assign out_overflow     = w_head.ovf;
    assign out_underflow    = w_head.unf;
    assign sticky_overflow  = r_sticky_ovf;
    assign sticky_underflow = r_sticky_unf;
    assign sticky_invalid   = r_sticky_inv;
    assign count            = r_count;

endmodule

// File: tb/tb_fp_addsub_collect.sv
// Directed self-checking bench for fp_addsub_collect with hand-computed
// expectations for ordering, classification, sticky flags and reset.
module tb_fp_addsub_collect;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_class;
    logic        out_overflow;
    logic        out_underflow;
    logic        sticky_overflow;
    logic        sticky_underflow;
    logic        sticky_invalid;
    logic        clr_sticky;
    logic [2:0]  count;

    int n_checks;
    int n_errors;

    fp_addsub_collect #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_result        (in_result),
        .in_overflow      (in_overflow),
        .in_underflow     (in_underflow),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_class        (out_class),
        .out_overflow     (out_overflow),
        .out_underflow    (out_underflow),
        .sticky_overflow  (sticky_overflow),
        .sticky_underflow (sticky_underflow),
        .sticky_invalid   (sticky_invalid),
        .clr_sticky       (clr_sticky),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v, input logic ovf, input logic unf);
        in_valid     = 1'b1;
        in_result    = v;
        in_overflow  = ovf;
        in_underflow = unf;
        tick();
        in_valid     = 1'b0;
        in_overflow  = 1'b0;
        in_underflow = 1'b0;
    endtask

    logic [31:0] vals [4];
    logic [31:0] cls  [4];

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_result    = 32'h0;
        in_overflow  = 1'b0;
        in_underflow = 1'b0;
        out_ready    = 1'b0;
        clr_sticky   = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check("rst_count",     32'(count), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sticky",    32'({sticky_overflow, sticky_underflow, sticky_invalid}), 32'd0);
        check("rst_out_res",   out_result, 32'h0);
        check("rst_out_cls",   32'(out_class), 32'd0);

        // Fill to capacity, then drain in order
        vals = '{32'h3F800000, 32'h80000000, 32'h00000001, 32'h7F800000};
        cls  = '{32'd2, 32'd0, 32'd1, 32'd3};
        for (int i = 0; i < 4; i++) push(vals[i], 1'b0, 1'b0);
        check("full_count",    32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_res",   out_result, vals[i]);
            check("drain_cls",   32'(out_class), cls[i]);
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_count", 32'(count), 32'd0);

        // NaN classes and invalid sticky
        push(32'hFFFFFFFF, 1'b0, 1'b0);
        check("qnan_sticky", 32'(sticky_invalid), 32'd1);
        push(32'h7F800001, 1'b0, 1'b0);
        check("qnan_cls", 32'(out_class), 32'd4);
        out_ready = 1'b1;
        tick();
        check("snan_cls", 32'(out_class), 32'd5);
        tick();
        out_ready  = 1'b0;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clr_inv", 32'(sticky_invalid), 32'd0);
        clr_sticky = 1'b1;
        push(32'h7FC00000, 1'b0, 1'b0);
        clr_sticky = 1'b0;
        check("clr_vs_set", 32'(sticky_invalid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready  = 1'b0;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;

        // Per-entry overflow/underflow flags
        push(32'h7F800000, 1'b1, 1'b0);
        push(32'h00000000, 1'b0, 1'b1);
        check("ovf_res", out_result, 32'h7F800000);
        check("ovf_flags", 32'({out_overflow, out_underflow}), 32'b10);
        out_ready = 1'b1;
        tick();
        check("unf_res", out_result, 32'h00000000);
        check("unf_flags", 32'({out_overflow, out_underflow}), 32'b01);
        tick();
        out_ready = 1'b0;
        check("flags_empty", 32'(out_valid), 32'd0);
        check("sticky_after_pop",
              32'({sticky_overflow, sticky_underflow, sticky_invalid}), 32'b110);

        // Continuous streaming: one push and one pop per cycle
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_result = 32'h40000000;
        tick();
        for (int i = 1; i < 10; i++) begin
            in_result = 32'h40000000 + 32'(i);
            check("stream_count", 32'(count), 32'd1);
            check("stream_res",   out_result, 32'h40000000 + 32'(i - 1));
            tick();
        end
        in_valid = 1'b0;
        check("stream_last", out_result, 32'h40000009);
        tick();
        out_ready = 1'b0;
        check("stream_empty", 32'(count), 32'd0);

        // Full FIFO refuses a push even when a pop happens in the same cycle
        for (int i = 0; i < 4; i++) push(32'h41000000 + 32'(i), 1'b0, 1'b0);
        in_valid  = 1'b1;
        in_result = 32'h42000000;
        out_ready = 1'b1;
        check("full_refuse_rdy", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_head",  out_result, 32'h41000001);
        tick();
        in_valid = 1'b0;
        check("full_next_push", 32'(count), 32'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("arst_count",     32'(count), 32'd0);
        check("arst_valid",     32'(out_valid), 32'd0);
        check("arst_ready",     32'(in_ready), 32'd1);
        check("arst_res",       out_result, 32'h0);
        check("arst_sticky",
              32'({sticky_overflow, sticky_underflow, sticky_invalid}), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
